// File: rtl/ps2_kbd_event_ctrl.sv
// ps2_kbd_event_ctrl
// Decodes PS/2 scan-code strobes (E0/F0 prefixes) into 10-bit key events
// {brk, ext, code}, buffers them in a FIFO and exposes DATA/STATUS/CTRL
// registers plus a level interrupt to the CPU bus.
//
// Optional build macro: PS2_TYPEMATIC_FILTER_EN
//   When defined, repeated make events for the key already held down
//   (typematic auto-repeat) are suppressed before they reach the FIFO.
//
// Bus handshake: re_i / we_i are single-cycle strobes qualified by addr_i.
// A read strobe is always accepted; rdata_o carries the answer on the
// following cycle and holds it until the next read strobe. A DATA read
// pops the FIFO in the strobe cycle when the FIFO is not empty.
module ps2_kbd_event_ctrl #(
   parameter int FIFO_DEPTH        = 8,
   parameter int CLK_FREQ          = 10_000_000,
   parameter int PREFIX_TIMEOUT_US = 2000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        code_valid_i,
   input  logic [7:0]  code_i,
   input  logic [1:0]  addr_i,
   input  logic        we_i,
   input  logic        re_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Prefix timeout in clock cycles, computed in 64 bits to avoid overflow.
   localparam longint TO_RAW   = (longint'(PREFIX_TIMEOUT_US) * longint'(CLK_FREQ))
                                 / longint'(1_000_000);
   localparam longint TO_LIMIT = (TO_RAW < 1) ? longint'(1) : TO_RAW;
   localparam int     TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   // Encoding doubles as the STATUS[5:4] state field.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   state_t            state;
   state_t            dec_state;
   logic [TO_W-1:0]   to_cnt;
   logic              dec_emit;
   logic [9:0]        dec_evt;
   logic              filt_emit;
   logic              push_q;
   logic [9:0]        evt_q;

   logic              enable;
   logic              irq_en;
   logic              overflow;

   logic [9:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;

   logic              empty;
   logic              full;
   logic              pop;
   logic              push_ok;
   logic              drop;
   logic              flush;
   logic              ctrl_wr;
   logic              ovf_clr;
   logic              irq_en_nxt;
   logic [31:0]       status_word;
   logic [31:0]       ctrl_word;

   // ------------------------------------------------------------------
   // Register-access decode
   // ------------------------------------------------------------------
   assign ctrl_wr    = we_i && (addr_i == ADDR_CTRL);
   assign flush      = ctrl_wr && wdata_i[2];
   assign ovf_clr    = we_i && (addr_i == ADDR_STATUS) && wdata_i[2];
   assign irq_en_nxt = ctrl_wr ? wdata_i[1] : irq_en;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign pop     = re_i && (addr_i == ADDR_DATA) && !empty && !flush;
   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // is still accepted when the CPU is reading.
   assign push_ok = push_q && (!full || pop) && !flush;
   assign drop    = push_q && full && !pop && !flush;

   assign status_word = {16'd0, 8'(count), 2'b00, 2'(state), 1'b0,
                         overflow, full, !empty};
   assign ctrl_word   = {30'd0, irq_en, enable};

   // ------------------------------------------------------------------
   // Scan-code decode: next state and event for the current strobe
   // ------------------------------------------------------------------
   always_comb begin
      dec_state = state;
      dec_emit  = 1'b0;
      dec_evt   = {2'b00, code_i};
      case (state)
         S_IDLE: begin
            if (code_i == CODE_EXT) begin
               dec_state = S_EXT;
            end else if (code_i == CODE_BRK) begin
               dec_state = S_BRK;
            end else begin
               dec_emit = 1'b1;
               dec_evt  = {2'b00, code_i};
            end
         end
         S_EXT: begin
            if (code_i == CODE_BRK) begin
               dec_state = S_EXT_BRK;
            end else if (code_i == CODE_EXT) begin
               dec_state = S_EXT;
            end else begin
               dec_emit  = 1'b1;
               dec_evt   = {2'b01, code_i};
               dec_state = S_IDLE;
            end
         end
         S_BRK: begin
            // After a break prefix every byte is taken as the key code.
            dec_emit  = 1'b1;
            dec_evt   = {2'b10, code_i};
            dec_state = S_IDLE;
         end
         S_EXT_BRK: begin
            dec_emit  = 1'b1;
            dec_evt   = {2'b11, code_i};
            dec_state = S_IDLE;
         end
         default: begin
            dec_state = S_IDLE;
         end
      endcase
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   // ------------------------------------------------------------------
   // Typematic filter: remember the last make key, drop its repeats
   // ------------------------------------------------------------------
   logic       lm_valid;
   logic [8:0] lm_key;
   logic       lm_match;

   assign lm_match  = lm_valid && (lm_key == dec_evt[8:0]);
   assign filt_emit = dec_emit && !(!dec_evt[9] && lm_match);

   // Track the held key: new make replaces it, matching break releases it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lm_valid <= 1'b0;
         lm_key   <= '0;
      end else if (flush) begin
         lm_valid <= 1'b0;
         lm_key   <= '0;
      end else if (code_valid_i && enable && dec_emit) begin
         if (!dec_evt[9]) begin
            if (!lm_match) begin
               lm_valid <= 1'b1;
               lm_key   <= dec_evt[8:0];
            end
         end else if (lm_match) begin
            lm_valid <= 1'b0;
         end
      end
   end
`else
   assign filt_emit = dec_emit;
`endif

   // ------------------------------------------------------------------
   // Decoder FSM with prefix timeout; registers the event to push
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         to_cnt <= '0;
         push_q <= 1'b0;
         evt_q  <= '0;
      end else begin
         push_q <= 1'b0;
         if (flush) begin
            state  <= S_IDLE;
            to_cnt <= '0;
         end else if (code_valid_i) begin
            // Any strobe restarts the timeout window, even while disabled.
            to_cnt <= '0;
            if (enable) begin
               state  <= dec_state;
               push_q <= filt_emit;
               evt_q  <= dec_evt;
            end
         end else if (state == S_IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            // Abandon a half-received sequence; nothing is pushed.
            state  <= S_IDLE;
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO occupancy next value (shared by the FIFO and the interrupt)
   // ------------------------------------------------------------------
   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (push_ok && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !push_ok) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // FIFO pointers and count; pointers wrap naturally at power-of-two depth.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_nxt;
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_ptr] <= evt_q;
      end
   end

   // CTRL bits and sticky overflow; a dropped push beats a clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         enable   <= 1'b1;
         irq_en   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            enable <= wdata_i[0];
            irq_en <= wdata_i[1];
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   // Registered read data; holds between read strobes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_o <= '0;
      end else if (re_i) begin
         case (addr_i)
            ADDR_DATA:   rdata_o <= empty ? 32'd0 : {1'b1, 21'd0, mem[rd_ptr]};
            ADDR_STATUS: rdata_o <= status_word;
            ADDR_CTRL:   rdata_o <= ctrl_word;
            default:     rdata_o <= 32'd0;
         endcase
      end
   end

   // Level interrupt from next-cycle occupancy so it drops right after the
   // emptying pop and rises as soon as an event lands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= irq_en_nxt && (count_nxt != '0);
      end
   end

endmodule

// File: tb/tb_ps2_kbd_event_ctrl.sv
// Testbench for ps2_kbd_event_ctrl: directed scenarios followed by random
// traffic, all checked against an event-level reference model.
module tb_ps2_kbd_event_ctrl;

   localparam int DEPTH     = 8;
   localparam int CLK_FREQ  = 1_000_000;
   localparam int TO_US     = 100;
   localparam int TO_CYCLES = TO_US * CLK_FREQ / 1_000_000;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        code_valid;
   logic [7:0]  code;
   logic [1:0]  addr;
   logic        we;
   logic        re;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   always #5 clk = ~clk;

   ps2_kbd_event_ctrl #(
      .FIFO_DEPTH        (DEPTH),
      .CLK_FREQ          (CLK_FREQ),
      .PREFIX_TIMEOUT_US (TO_US)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .code_valid_i (code_valid),
      .code_i       (code),
      .addr_i       (addr),
      .we_i         (we),
      .re_i         (re),
      .wdata_i      (wdata),
      .rdata_o      (rdata),
      .irq_o        (irq)
   );

   // ---------------- counters and scoreboard ----------------
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        rd_pend;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // A read strobe seen at a rising edge means rdata is fresh afterwards.
   always @(posedge clk or posedge rst) begin
      if (rst) rd_pend <= 1'b0;
      else     rd_pend <= re;
   end

   // Monitor: compare each presented read result with the queued expectation.
   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read: got=%h want=none", rdata);
         end else begin
            logic [31:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, rdata, e);
         end
      end
   end

   // ---------------- reference model (event level) ----------------
   int m_fifo[$];
   bit m_ext, m_brk, m_ovf, m_en, m_irq_en;
   bit lm_valid;
   int lm_key;

   function automatic void m_reset();
      m_fifo.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_en = 1; m_irq_en = 0;
      lm_valid = 0; lm_key = 0;
   endfunction

   function automatic void m_emit(int ev);
`ifdef PS2_TYPEMATIC_FILTER_EN
      bit mk;
      int key;
      mk  = ((ev >> 9) & 1) == 0;
      key = ev & 'h1FF;
      if (mk && lm_valid && lm_key == key) return;
      if (mk) begin
         lm_valid = 1;
         lm_key   = key;
      end else if (lm_valid && lm_key == key) begin
         lm_valid = 0;
      end
`endif
      if (m_fifo.size() == DEPTH) m_ovf = 1;
      else m_fifo.push_back(ev);
   endfunction

   // Prefix bytes accumulate until a key byte arrives; once a break prefix
   // is pending, any byte is the key.
   function automatic void m_code(int c);
      if (!m_en) return;
      if (!m_brk && c == 'hE0)      m_ext = 1;
      else if (!m_brk && c == 'hF0) m_brk = 1;
      else begin
         m_emit((int'(m_brk) << 9) | (int'(m_ext) << 8) | c);
         m_ext = 0;
         m_brk = 0;
      end
   endfunction

   function automatic logic [31:0] m_read(logic [1:0] a);
      logic [31:0] r;
      int ev;
      r = '0;
      case (a)
         2'd0: if (m_fifo.size() != 0) begin
            ev = m_fifo.pop_front();
            r  = 32'h8000_0000 | 32'(ev);
         end
         2'd1: begin
            r[0]    = m_fifo.size() != 0;
            r[1]    = m_fifo.size() == DEPTH;
            r[2]    = m_ovf;
            r[4]    = m_ext;
            r[5]    = m_brk;
            r[15:8] = 8'(m_fifo.size());
         end
         2'd2: begin
            r[0] = m_en;
            r[1] = m_irq_en;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic void m_write(logic [1:0] a, logic [31:0] d);
      if (a == 2'd1 && d[2]) m_ovf = 0;
      if (a == 2'd2) begin
         m_en     = d[0];
         m_irq_en = d[1];
         if (d[2]) begin
            m_fifo.delete();
            m_ext = 0; m_brk = 0; lm_valid = 0;
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_code(logic [7:0] c);
      @(negedge clk);
      code_valid = 1'b1;
      code       = c;
      m_code(int'(c));
      @(negedge clk);
      code_valid = 1'b0;
      idle(2);
   endtask

   task automatic read_reg(logic [1:0] a, string nm);
      @(negedge clk);
      re   = 1'b1;
      addr = a;
      exp_q.push_back(m_read(a));
      name_q.push_back(nm);
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic write_reg(logic [1:0] a, logic [31:0] d);
      @(negedge clk);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      m_write(a, d);
      @(negedge clk);
      we = 1'b0;
   endtask

   // Scan-code strobe and DATA read issued in the same cycle.
   task automatic code_and_read(logic [7:0] c, string nm);
      @(negedge clk);
      code_valid = 1'b1;
      code       = c;
      re         = 1'b1;
      addr       = 2'd0;
      exp_q.push_back(m_read(2'd0));
      name_q.push_back(nm);
      m_code(int'(c));
      @(negedge clk);
      code_valid = 1'b0;
      re         = 1'b0;
      idle(2);
   endtask

   function automatic logic [7:0] pick_code();
      case ($urandom_range(0, 5))
         0:       return 8'hE0;
         1:       return 8'hF0;
         2:       return 8'h1C;
         3:       return 8'h75;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int since;
      rst = 1'b1; code_valid = 0; code = 0; addr = 0; we = 0; re = 0; wdata = 0;
      m_reset();
      idle(3);
      check("reset_rdata", rdata, 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      read_reg(2'd2, "reset_ctrl");
      read_reg(2'd1, "reset_status");

      // Make / break of a plain key, then empty read.
      send_code(8'h1C); send_code(8'hF0); send_code(8'h1C);
      read_reg(2'd0, "make_1c");
      read_reg(2'd0, "break_1c");
      read_reg(2'd0, "empty_read");

      // Extended key, with state visible after the lone E0.
      send_code(8'hE0);
      read_reg(2'd1, "status_ext");
      send_code(8'h75);
      send_code(8'hE0); send_code(8'hF0); send_code(8'h75);
      read_reg(2'd0, "ext_make");
      read_reg(2'd0, "ext_break");

      // Overflow, clearing it, same-cycle push/pop at full, drain.
      for (int i = 0; i <= DEPTH; i++) send_code(8'(8'h15 + i));
      read_reg(2'd1, "status_full_ovf");
      write_reg(2'd1, 32'h4);
      read_reg(2'd1, "status_ovf_clr");
      code_and_read(8'h20, "full_pushpop_data");
      read_reg(2'd1, "status_full_pushpop");
      for (int i = 0; i < DEPTH; i++) read_reg(2'd0, "drain");
      read_reg(2'd0, "drain_empty");
      code_and_read(8'h33, "empty_pushpop_data");
      read_reg(2'd0, "empty_pushpop_stored");

      // Prefix timeout.
      send_code(8'hE0);
      read_reg(2'd1, "status_before_to");
      idle(TO_CYCLES + 20);
      m_ext = 0; m_brk = 0;
      read_reg(2'd1, "status_after_to");
      send_code(8'h1C);
      read_reg(2'd0, "after_to_event");

      // Interrupt assertion and clear.
      write_reg(2'd2, 32'h3);
      @(negedge clk);
      code_valid = 1'b1; code = 8'h1C; m_code(32'h1C);
      @(negedge clk);
      code_valid = 1'b0;
      @(negedge clk);
      check("irq_set", 32'(irq), 32'(m_irq_en && m_fifo.size() != 0));
      read_reg(2'd0, "irq_pop");
      check("irq_clear", 32'(irq), 32'(m_irq_en && m_fifo.size() != 0));

      // Flush and disabled decoding.
      send_code(8'h11); send_code(8'h12); send_code(8'hE0);
      write_reg(2'd2, 32'h7);
      read_reg(2'd1, "status_flush");
      read_reg(2'd2, "ctrl_after_flush");
      write_reg(2'd2, 32'h0);
      send_code(8'h1C);
      read_reg(2'd1, "status_disabled");
      write_reg(2'd2, 32'h1);
      read_reg(2'd3, "reserved_read");

      // Typematic repeat pattern (filtered only when the feature is built).
      send_code(8'h1C); send_code(8'h1C); send_code(8'h1C);
      send_code(8'hF0); send_code(8'h1C); send_code(8'h1C);
      for (int i = 0; i < 5; i++) read_reg(2'd0, "typematic");

      // Asynchronous reset mid-sequence with entries queued.
      write_reg(2'd2, 32'h3);
      send_code(8'h21); send_code(8'h22); send_code(8'h23); send_code(8'hE0);
      read_reg(2'd1, "status_pre_reset");
      check("irq_pre_reset", 32'(irq), 32'(m_irq_en && m_fifo.size() != 0));
      idle(1);
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      check("async_rst_rdata", rdata, 32'd0);
      check("async_rst_irq", 32'(irq), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      read_reg(2'd1, "status_post_reset");
      read_reg(2'd2, "ctrl_post_reset");

      // Random traffic.
      since = 0;
      for (int i = 0; i < 300; i++) begin
         int op;
         op = $urandom_range(0, 99);
         if (op < 50 || ((m_ext || m_brk) && since >= 4)) begin
            send_code(pick_code());
            since = 0;
         end else if (op < 60) begin
            code_and_read(pick_code(), "rnd_code_read");
            since = 0;
         end else if (op < 82) begin
            read_reg(2'($urandom_range(0, 3)), "rnd_read");
         end else if (op < 90) begin
            write_reg(2'($urandom_range(0, 3)), $urandom());
         end else begin
            write_reg(2'd2, {29'd0, ($urandom_range(0, 9) == 0),
                             1'($urandom_range(0, 1)),
                             ($urandom_range(0, 4) != 0)});
         end
         since++;
      end
      write_reg(2'd2, 32'h1);
      read_reg(2'd1, "final_status");
      idle(3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
